poly_reader: RTL and testbench



---
 rtl/kyber_pkg.sv | 15 +
 rtl/poly_reader_pair_fifo2.sv | 56 +++++
 rtl/poly_reader.sv | 173 +++++++++++++++++
 tb/tb_poly_reader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the poly_reader FSM state encoding.
package kyber_pkg;

  localparam int KYBER_Q    = 3329;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/poly_reader_pair_fifo2.sv
// pair_fifo2: two-entry FIFO of coefficient pairs with occupancy count.
// A push and a pop in the same cycle are allowed, including when full.
module pair_fifo2
  import kyber_pkg::*;
#(
  parameter int WIDTH = 2 * DATA_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees the head slot, so a push into a full FIFO is fine on the same edge.
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign rdata   = mem[rd_ptr];

  // Entry storage; data words are not reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/poly_reader.sv
// poly_reader: unloads a 2^ADDR_W coefficient polynomial from the dual-port
// RAM (even address on port 1, odd on port 2) and serializes it into a
// valid/ready stream in ascending address order.
// Optional macro POLY_READER_FREDUCE_EN: reduce each word into [0, KYBER_Q-1]
// as it is written into the pair FIFO (latency unchanged).
module poly_reader #(
  parameter int ADDR_W  = kyber_pkg::ADDR_W_DEF,
  parameter int DATA_W  = kyber_pkg::DATA_W_DEF,
  parameter int KYBER_Q = kyber_pkg::KYBER_Q
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_re,
  output logic [ADDR_W-1:0]        ram_addr_1,
  output logic [ADDR_W-1:0]        ram_addr_2,
  input  logic signed [DATA_W-1:0] ram_dout_1,
  input  logic signed [DATA_W-1:0] ram_dout_2,
  output logic signed [DATA_W-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last
);

  import kyber_pkg::*;

  localparam int PW = ADDR_W - 1;
  localparam logic signed [DATA_W:0] Q_EXT = (DATA_W + 1)'(KYBER_Q);

  state_t              state;
  logic [PW-1:0]       p;
  logic                vld_p1;
  logic                half;
  logic [1:0]          count;
  logic [2*DATA_W-1:0] head;
  logic [2*DATA_W-1:0] wdata;
  logic                accept;
  logic                pop;
  logic [2:0]          occ;
  logic                issue_ok;
  logic                last_pair;
  logic                drain_done;

  // Conditional reduction into [0, Q-1]; exact for inputs in (-Q, 2Q).
  function automatic logic signed [DATA_W-1:0] freduce(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W:0] xe;
    logic signed [DATA_W:0] r;
    xe = {x[DATA_W-1], x};
    if (xe < 0) begin
      r = xe + Q_EXT;
    end else if (xe >= Q_EXT) begin
      r = xe - Q_EXT;
    end else begin
      r = xe;
    end
    return r[DATA_W-1:0];
  endfunction

`ifdef POLY_READER_FREDUCE_EN
  assign wdata = {freduce(ram_dout_2), freduce(ram_dout_1)};
`else
  assign wdata = {ram_dout_2, ram_dout_1};
`endif

  pair_fifo2 #(
    .WIDTH (2 * DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (vld_p1),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .count (count)
  );

  // Stream side: valid comes only from FIFO occupancy, never from m_ready.
  assign m_valid = (count != 2'd0);
  assign accept  = m_valid && m_ready;
  assign pop     = accept && half;

  // Pairs held or on their way, after crediting this cycle's pop.
  assign occ      = {1'b0, count} + {2'b00, ram_re} + {2'b00, vld_p1} - {2'b00, pop};
  assign issue_ok = (occ < 3'd2);

  // Once every pair is issued and nothing is in flight, a lone head is the final pair.
  assign last_pair  = (state == ST_DRAIN) && (count == 2'd1) && !ram_re && !vld_p1;
  assign drain_done = last_pair && pop;
  assign m_last     = half && last_pair;

  // Word select from the head pair; zero when nothing is presented.
  always_comb begin
    m_data = '0;
    if (m_valid) begin
      m_data = half ? head[2*DATA_W-1:DATA_W] : head[DATA_W-1:0];
    end
  end

  // Read pipeline stage: data for a pair issued last cycle sits on ram_dout now.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= ram_re;
    end
  end

  // Serializer half select: even word first, odd word pops the pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      half <= 1'b0;
    end else if (accept) begin
      half <= ~half;
    end
  end

  // Control FSM with registered busy/done and RAM read issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      p          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ram_re     <= 1'b0;
      ram_addr_1 <= '0;
      ram_addr_2 <= ADDR_W'(1);
    end else begin
      ram_re <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            // Pair 0 is issued on the accepting edge so the first beat lands at start+3.
            state      <= ST_READ;
            busy       <= 1'b1;
            ram_re     <= 1'b1;
            ram_addr_1 <= '0;
            ram_addr_2 <= ADDR_W'(1);
            p          <= PW'(1);
          end
        end
        ST_READ: begin
          if (issue_ok) begin
            ram_re     <= 1'b1;
            ram_addr_1 <= {p, 1'b0};
            ram_addr_2 <= {p, 1'b1};
            if (p == '1) begin
              state <= ST_DRAIN;
            end else begin
              p <= p + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_reader.sv
// Scoreboard bench for poly_reader: expected beats are queued when an unload
// is started and popped by a monitor on every accepted beat.
module tb_poly_reader;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int N  = 256;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT (ADDR_W = 8)
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic                 m_ready = 1'b0;
  logic                 busy, done, ram_re, m_valid, m_last;
  logic [AW-1:0]        a1, a2;
  logic signed [DW-1:0] d1, d2, m_data;
  logic signed [DW-1:0] mem [N];

  poly_reader dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .ram_re(ram_re), .ram_addr_1(a1), .ram_addr_2(a2),
    .ram_dout_1(d1), .ram_dout_2(d2),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always @(posedge clk) if (ram_re) begin d1 <= mem[a1]; d2 <= mem[a2]; end

  // Small DUT (ADDR_W = 2)
  logic                 start_s = 1'b0;
  logic                 m_ready_s = 1'b1;
  logic                 busy_s, done_s, ram_re_s, m_valid_s, m_last_s;
  logic [1:0]           a1_s, a2_s;
  logic signed [DW-1:0] d1_s, d2_s, m_data_s;
  logic signed [DW-1:0] mem_s [4];

  poly_reader #(.ADDR_W(2)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .busy(busy_s), .done(done_s),
    .ram_re(ram_re_s), .ram_addr_1(a1_s), .ram_addr_2(a2_s),
    .ram_dout_1(d1_s), .ram_dout_2(d2_s),
    .m_data(m_data_s), .m_valid(m_valid_s), .m_ready(m_ready_s), .m_last(m_last_s)
  );

  always @(posedge clk) if (ram_re_s) begin d1_s <= mem_s[a1_s]; d2_s <= mem_s[a2_s]; end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_word(input int x);
`ifdef POLY_READER_FREDUCE_EN
    if (x < 0) return x + 3329;
    if (x >= 3329) return x - 3329;
`endif
    return x;
  endfunction

  exp_t sb[$];
  exp_t sb_s[$];
  int   beats, pops, issued, first_cyc, done_cnt, start_cyc;
  int   beats_s, done_cnt_s;
  int   ready_mode = 0;

  // m_ready driver: 0 = always ready, 1 = random 50 %, 2 = held low
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  // Monitor for the main DUT
  initial begin : mon
    exp_t                 e;
    bit                   prev_stall = 0;
    bit                   prev_lastacc = 0;
    logic signed [DW-1:0] prev_data = '0;
    logic                 prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall   = 0;
        prev_lastacc = 0;
      end else begin
        if (prev_lastacc || done) check("done_timing", done, prev_lastacc);
        if (done) done_cnt++;
        prev_lastacc = 0;
        if (ram_re) begin
          issued++;
          check("outstanding_le_2", (issued - pops) <= 2, 1);
        end
        if (prev_stall) begin
          check("stall_valid", m_valid, 1);
          check("stall_data", m_data, prev_data);
          check("stall_last", m_last, prev_last);
        end
        if (m_valid) begin
          check("busy_with_valid", busy, 1);
          if (first_cyc < 0) first_cyc = cyc;
        end
        if (m_valid && m_ready) begin
          check("beat_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("beat_data", m_data, e.data);
            check("beat_last", m_last, e.last);
            prev_lastacc = e.last;
          end
          beats++;
          if (beats % 2 == 0) pops++;
          prev_stall = 0;
        end else begin
          prev_stall = m_valid;
          prev_data  = m_data;
          prev_last  = m_last;
        end
      end
    end
  end

  // Monitor for the small DUT (always ready)
  initial begin : mon_s
    exp_t e;
    bit   prev_lastacc = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (prev_lastacc || done_s) check("small_done_timing", done_s, prev_lastacc);
        if (done_s) done_cnt_s++;
        prev_lastacc = 0;
        if (m_valid_s && m_ready_s) begin
          check("small_beat_expected", sb_s.size() != 0, 1);
          if (sb_s.size() != 0) begin
            e = sb_s.pop_front();
            check("small_beat_data", m_data_s, e.data);
            check("small_beat_last", m_last_s, e.last);
            prev_lastacc = e.last;
          end
          beats_s++;
        end
      end
    end
  end

  task automatic clear_run();
    beats = 0; pops = 0; issued = 0; first_cyc = -1; done_cnt = 0;
    sb.delete();
  endtask

  task automatic push_expected();
    for (int k = 0; k < N; k++) sb.push_back('{ref_word(int'(mem[k])), k == N - 1});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // One full unload; optionally re-pulses start at beat 40
  task automatic run_full(input int mode, input bit restart);
    bit sent = 0;
    clear_run();
    ready_mode = mode;
    push_expected();
    pulse_start();
    @(negedge clk);
    check("busy_after_start", busy, 1);
    for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
      @(negedge clk);
      if (restart && !sent && beats >= 40) begin
        sent = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    check("done_within_bound", done_cnt, 1);
    repeat (4) @(negedge clk);
    check("beat_count", beats, N);
    check("done_count", done_cnt, 1);
    check("scoreboard_empty", sb.size(), 0);
    check("busy_after_done", busy, 0);
    if (mode == 0) check("first_beat_latency", first_cyc - start_cyc, 3);
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = DW'(13 * i);
    mem_s[0] = 16'sd7; mem_s[1] = -16'sd3; mem_s[2] = 16'sd100; mem_s[3] = 16'sd3328;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ram_re", ram_re, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_addr_1", a1, 0);
    check("rst_addr_2", a2, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Full-rate, random back-pressure, ignored restart
    run_full(0, 0);
    run_full(1, 0);
    run_full(0, 1);

    // Reset in the middle of an unload
    clear_run();
    ready_mode = 0;
    push_expected();
    pulse_start();
    for (int i = 0; i < 2000 && beats < 100; i++) @(negedge clk);
    check("reached_beat_100", beats >= 100, 1);
    ready_mode = 2;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    ready_mode = 0;
    @(negedge clk);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    repeat (10) @(negedge clk);
    check("midrst_no_done", done_cnt, 0);
    run_full(0, 0);

    // Small polynomial: 4 beats
    beats_s = 0; done_cnt_s = 0;
    sb_s.delete();
    for (int k = 0; k < 4; k++) sb_s.push_back('{ref_word(int'(mem_s[k])), k == 3});
    @(posedge clk); #1;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int i = 0; i < 50 && done_cnt_s == 0; i++) @(negedge clk);
    check("small_done_seen", done_cnt_s, 1);
    check("small_beat_count", beats_s, 4);

    // Out-of-range words: reduced with the option, bit-exact without
    mem[0] = 16'sd3400;
    mem[1] = -16'sd5;
    run_full(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
